// File: rtl/ws2812b_tx.sv
// ----------------------------------------------------------------------------
// ws2812b_tx
//   Serialises 24-bit pixel words onto the single-wire WS2812B LED strip.
//   Each bit is a BIT_CYCLES period that starts high and falls after
//   T1H_CYCLES ('1') or T0H_CYCLES ('0'). Words go out MSB first, unchanged.
//   A pixel flagged with latch is followed by a RESET_CYCLES low period.
//   The same low period runs after every reset release, so the strip always
//   starts from a known state.
//
// Ports
//   clk      in   1   system clock (20 MHz nominal)
//   rst_n    in   1   asynchronous active-low reset
//   data_in  in  24   pixel word, sent MSB first
//   valid    in   1   data_in/latch valid; only looked at while ready=1
//   latch    in   1   this pixel ends the frame; sampled with data_in
//   ready    out  1   a pixel can be accepted this cycle
//   led      out  1   strip data line
// ----------------------------------------------------------------------------
module ws2812b_tx #(
  parameter int unsigned T0H_CYCLES   = 8,
  parameter int unsigned T1H_CYCLES   = 16,
  parameter int unsigned BIT_CYCLES   = 25,
  parameter int unsigned RESET_CYCLES = 6000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] data_in,
  input  logic        valid,
  input  logic        latch,
  output logic        ready,
  output logic        led
);

  // One counter serves both the bit period and the reset low period.
  localparam int CW = $clog2(RESET_CYCLES + 1);

  localparam logic [CW-1:0] RESET_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T0H_C      = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1H_C      = CW'(T1H_CYCLES);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_IDLE,
    ST_SEND
  } state_e;

  state_e          state_q;
  logic [23:0]     shreg_q;
  logic [4:0]      bit_cnt_q;
  logic [CW-1:0]   cyc_cnt_q;
  logic            latch_q;
  logic            led_q;
  logic            ready_q;

  // High time of the bit currently at the head of the shift register.
  logic [CW-1:0]   high_cycles;
  assign high_cycles = shreg_q[23] ? T1H_C : T0H_C;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RESET;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
      latch_q   <= 1'b0;
      led_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RESET: begin
          led_q <= 1'b0;
          if (cyc_cnt_q == RESET_LAST) begin
            cyc_cnt_q <= '0;
            ready_q   <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            cyc_cnt_q <= cyc_cnt_q + 1'b1;
          end
        end

        ST_IDLE: begin
          // ready_q is always 1 here, so valid alone is the handshake.
          led_q <= 1'b0;
          if (valid) begin
            shreg_q   <= data_in;
            latch_q   <= latch;
            ready_q   <= 1'b0;
            bit_cnt_q <= 5'd23;
            cyc_cnt_q <= '0;
            state_q   <= ST_SEND;
          end
        end

        ST_SEND: begin
          // led is registered, so it trails the cycle counter by one edge;
          // the first rise therefore lands on the edge after acceptance.
          led_q <= (cyc_cnt_q < high_cycles);
          if (cyc_cnt_q == BIT_LAST) begin
            cyc_cnt_q <= '0;
            shreg_q   <= {shreg_q[22:0], 1'b0};
            bit_cnt_q <= bit_cnt_q - 1'b1;
            if (bit_cnt_q == 5'd0) begin
              state_q <= latch_q ? ST_RESET : ST_IDLE;
              ready_q <= ~latch_q;
            end
          end else begin
            cyc_cnt_q <= cyc_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_RESET;
          ready_q <= 1'b0;
          led_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign led   = led_q;

endmodule
